// File: rtl/ball_physics.sv
// ball_physics: frame-rate ball integrator (gravity, floor bounce, hoop detection) feeding pixel_Gen.
// Build option WALL_BOUNCE_EN: side walls reflect the ball instead of ending the shot.
module ball_physics #(
   parameter int FRAC_BITS    = 4,
   parameter int GRAVITY      = 6,
   parameter int START_X      = 80,
   parameter int START_Y      = 400,
   parameter int FLOOR_Y      = 460,
   parameter int BALL_R       = 8,
   parameter int X_MAX        = 639,
   parameter int HOOP_X0      = 520,
   parameter int HOOP_X1      = 560,
   parameter int HOOP_Y       = 200,
   parameter int MAX_BOUNCE   = 3,
   parameter int SCORE_FRAMES = 60,
   parameter int V_ACTIVE     = 480
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic        p_tick,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        launch,
   input  logic [11:0] vx0,
   input  logic [11:0] vy0,
   output logic [9:0]  ball_x,
   output logic [9:0]  ball_y,
   output logic        in_flight,
   output logic        score_pulse,
   output logic [1:0]  bounce_cnt,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLIGHT = 2'd1,
      S_SCORED = 2'd2,
      S_REST   = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(SCORE_FRAMES + 1);

   localparam logic [13:0]        L_START_X    = 14'(START_X << FRAC_BITS);
   localparam logic [13:0]        L_START_Y    = 14'(START_Y << FRAC_BITS);
   localparam logic signed [15:0] L_GRAV       = 16'(GRAVITY);
   localparam logic signed [15:0] L_FLOOR      = 16'((FLOOR_Y - BALL_R) << FRAC_BITS);
   localparam logic signed [15:0] L_HOOP_Y     = 16'(HOOP_Y << FRAC_BITS);
   localparam logic signed [15:0] L_HOOP_X0    = 16'(HOOP_X0 << FRAC_BITS);
   localparam logic signed [15:0] L_HOOP_X1    = 16'(((HOOP_X1 + 1) << FRAC_BITS) - 1);
   localparam logic signed [15:0] L_X_LO       = 16'(BALL_R << FRAC_BITS);
   localparam logic signed [15:0] L_X_HI       = 16'((X_MAX - BALL_R) << FRAC_BITS);
   localparam logic signed [15:0] L_ONE        = 16'(1 << FRAC_BITS);
   localparam logic [1:0]         L_MAX_B      = 2'(MAX_BOUNCE);
   localparam logic [CNT_W-1:0]   L_SCORE_LAST = CNT_W'(SCORE_FRAMES - 1);

   state_t                r_state;
   logic [13:0]           r_x;
   logic [13:0]           r_y;
   logic signed [11:0]    r_vx;
   logic signed [11:0]    r_vy;
   logic [1:0]            r_bounce;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_score;
   logic                  r_in_flight;
   logic                  r_launch_d;

   state_t                w_state_n;
   logic [13:0]           w_x_nx;
   logic [13:0]           w_y_nx;
   logic signed [11:0]    w_vx_nx;
   logic signed [11:0]    w_vy_nx;
   logic [1:0]            w_bounce_nx;
   logic [CNT_W-1:0]      w_cnt_nx;
   logic                  w_score_nx;

   logic                  w_frame_tick;
   logic                  w_launch_rise;
   logic signed [15:0]    w_y_ext;
   logic signed [15:0]    w_vy_int;
   logic signed [15:0]    w_y_int;
   logic signed [15:0]    w_x_int;
   logic signed [15:0]    w_vy_half;
   logic signed [15:0]    w_vy_bnc;
   logic [1:0]            w_bounce_inc;
   logic                  w_hoop;
   logic                  w_floor;

   assign w_frame_tick  = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(V_ACTIVE));
   assign w_launch_rise = launch && !r_launch_d;

   // Semi-implicit step: velocity first, then position with the new velocity.
   assign w_y_ext      = $signed({2'b00, r_y});
   assign w_vy_int     = $signed({{4{r_vy[11]}}, r_vy}) + L_GRAV;
   assign w_y_int      = w_y_ext + w_vy_int;
   assign w_x_int      = $signed({2'b00, r_x}) + $signed({{4{r_vx[11]}}, r_vx});
   assign w_vy_half    = w_vy_int >>> 1;
   assign w_vy_bnc     = 16'sd0 - w_vy_half;
   assign w_bounce_inc = r_bounce + 2'd1;

   assign w_hoop  = (w_y_ext < L_HOOP_Y) && (w_y_int >= L_HOOP_Y) && (w_vy_int > 16'sd0) &&
                    (w_x_int >= L_HOOP_X0) && (w_x_int <= L_HOOP_X1);
   assign w_floor = (w_y_int >= L_FLOOR) && (w_vy_int > 16'sd0);

   // Next-state and datapath update for one frame of ball motion.
   always_comb begin
      w_state_n   = r_state;
      w_x_nx      = r_x;
      w_y_nx      = r_y;
      w_vx_nx     = r_vx;
      w_vy_nx     = r_vy;
      w_bounce_nx = r_bounce;
      w_cnt_nx    = r_cnt;
      w_score_nx  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_x_nx = L_START_X;
            w_y_nx = L_START_Y;
            if (w_launch_rise) begin
               w_vx_nx     = $signed(vx0);
               w_vy_nx     = $signed(vy0);
               w_bounce_nx = 2'd0;
               w_state_n   = S_FLIGHT;
            end else begin
               w_vx_nx = 12'sd0;
               w_vy_nx = 12'sd0;
            end
         end
         S_FLIGHT: begin
            if (w_frame_tick && w_hoop) begin
               w_x_nx     = w_x_int[13:0];
               w_y_nx     = w_y_int[13:0];
               w_vx_nx    = 12'sd0;
               w_vy_nx    = 12'sd0;
               w_cnt_nx   = '0;
               w_score_nx = 1'b1;
               w_state_n  = S_SCORED;
            end else if (w_frame_tick) begin
               if (w_floor) begin
                  w_y_nx      = L_FLOOR[13:0];
                  w_vy_nx     = w_vy_bnc[11:0];
                  w_bounce_nx = w_bounce_inc;
                  if ((w_bounce_inc == L_MAX_B) || (w_vy_half < L_ONE)) begin
                     w_vx_nx   = 12'sd0;
                     w_vy_nx   = 12'sd0;
                     w_state_n = S_REST;
                  end else begin
                     w_state_n = S_FLIGHT;
                  end
               end else if (w_y_int < 16'sd0) begin
                  w_y_nx  = 14'd0;
                  w_vy_nx = 12'sd0;
               end else begin
                  w_y_nx  = w_y_int[13:0];
                  w_vy_nx = w_vy_int[11:0];
               end
               if ((w_x_int < L_X_LO) || (w_x_int > L_X_HI)) begin
                  w_x_nx = (w_x_int < L_X_LO) ? L_X_LO[13:0] : L_X_HI[13:0];
`ifdef WALL_BOUNCE_EN
                  w_vx_nx = 12'sd0 - r_vx;
`else
                  w_vx_nx   = 12'sd0;
                  w_vy_nx   = 12'sd0;
                  w_state_n = S_REST;
`endif
               end else begin
                  w_x_nx = w_x_int[13:0];
               end
            end else begin
               w_state_n = S_FLIGHT;
            end
         end
         S_SCORED: begin
            if (w_frame_tick && (r_cnt == L_SCORE_LAST)) begin
               w_x_nx    = L_START_X;
               w_y_nx    = L_START_Y;
               w_cnt_nx  = '0;
               w_state_n = S_IDLE;
            end else if (w_frame_tick) begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end else begin
               w_cnt_nx = r_cnt;
            end
         end
         S_REST: begin
            if (w_launch_rise) begin
               w_x_nx    = L_START_X;
               w_y_nx    = L_START_Y;
               w_vx_nx   = 12'sd0;
               w_vy_nx   = 12'sd0;
               w_state_n = S_IDLE;
            end else begin
               w_state_n = S_REST;
            end
         end
         default: begin
            w_x_nx    = L_START_X;
            w_y_nx    = L_START_Y;
            w_state_n = S_IDLE;
         end
      endcase
   end

   // State, kinematic and output registers.
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_x         <= L_START_X;
         r_y         <= L_START_Y;
         r_vx        <= 12'sd0;
         r_vy        <= 12'sd0;
         r_bounce    <= 2'd0;
         r_cnt       <= '0;
         r_score     <= 1'b0;
         r_in_flight <= 1'b0;
         r_launch_d  <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_x         <= w_x_nx;
         r_y         <= w_y_nx;
         r_vx        <= w_vx_nx;
         r_vy        <= w_vy_nx;
         r_bounce    <= w_bounce_nx;
         r_cnt       <= w_cnt_nx;
         r_score     <= w_score_nx;
         r_in_flight <= (w_state_n == S_FLIGHT);
         r_launch_d  <= launch;
      end
   end

   assign ball_x      = r_x[FRAC_BITS +: 10];
   assign ball_y      = r_y[FRAC_BITS +: 10];
   assign in_flight   = r_in_flight;
   assign score_pulse = r_score;
   assign bounce_cnt  = r_bounce;
   assign state       = r_state;

endmodule
